z_result_buffer: RTL and testbench

//  Downstream stage of the ALU: captures the 64-bit ALU result (ZMuxIn) with its opcode
//  tag into a small FIFO. Presents the head entry as ZHighOut/ZLowOut to the bus/writeback

---
 rtl/z_result_buffer.sv | 143 ++++++++++++++
 tb/tb_z_result_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/z_result_buffer.sv
// ---------------------------------------------------------------------------
// z_result_buffer
// Downstream stage of the ALU. Each pushed 64-bit result is stored in a small
// FIFO together with its 5-bit opcode tag. The head entry is presented on
// ZHighOut/ZLowOut under a valid/ready handshake. Popping a mul or div result
// writes it into the HI/LO registers. The zero and negative flags describe
// the head entry.
//
// Ports
//   clock       in   1    system clock, rising edge
//   clear       in   1    asynchronous active-low reset
//   Zin         in   1    push strobe (captures ZMuxIn + ALUControl)
//   ALUControl  in   5    opcode tag of the pushed result
//   ZMuxIn      in   64   ALU result
//   in_ready    out  1    a push is accepted this cycle if Zin=1
//   out_valid   out  1    head entry available
//   out_ready   in   1    consumer takes the head entry this edge
//   ZHighOut    out  32   head[63:32], 0 when empty
//   ZLowOut     out  32   head[31:0], 0 when empty
//   HIOut       out  32   HI register
//   LOOut       out  32   LO register
//   flag_zero   out  1    head result is zero, 0 when empty
//   flag_neg    out  1    head result is negative, 0 when empty
//   count       out  CW   occupancy
//   ovf_err     out  1    sticky: a push was dropped
// ---------------------------------------------------------------------------
module z_result_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clock,
  input  logic                         clear,
  input  logic                         Zin,
  input  logic [4:0]                   ALUControl,
  input  logic [WIDTH-1:0]             ZMuxIn,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  ZHighOut,
  output logic [31:0]                  ZLowOut,
  output logic [31:0]                  HIOut,
  output logic [31:0]                  LOOut,
  output logic                         flag_zero,
  output logic                         flag_neg,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [4:0]    TAG_MUL  = 5'b01111;
  localparam logic [4:0]    TAG_DIV  = 5'b10000;

  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [4:0]       r_tag  [DEPTH];
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_ovf;

  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic             w_ready;
  logic [WIDTH-1:0] w_head_data;
  logic [4:0]       w_head_tag;
  logic             w_wide;

  // Wrap modulo DEPTH, so DEPTH does not have to be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_valid = (r_count != '0);
    // A full FIFO still takes a push when the head leaves on the same edge.
    w_ready = (r_count != FULL_CNT) | out_ready;
    w_push  = Zin & w_ready;
    w_pop   = w_valid & out_ready;

    // The head is forced to zero when empty, so the storage needs no reset.
    w_head_data = w_valid ? r_data[r_rptr] : '0;
    w_head_tag  = w_valid ? r_tag[r_rptr]  : '0;
    w_wide      = w_valid & ((w_head_tag == TAG_MUL) | (w_head_tag == TAG_DIV));

    if (w_wide) begin
      flag_zero = (w_head_data == '0);
      flag_neg  = w_head_data[63];
    end else begin
      flag_zero = w_valid & (w_head_data[31:0] == 32'd0);
      flag_neg  = w_head_data[31];
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = w_valid;
  assign ZHighOut  = w_head_data[63:32];
  assign ZLowOut   = w_head_data[31:0];
  assign HIOut     = r_hi;
  assign LOOut     = r_lo;
  assign count     = r_count;
  assign ovf_err   = r_ovf;

  // Entry storage (data qualified by r_count, no reset needed).
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_data[r_wptr] <= ZMuxIn;
      r_tag[r_wptr]  <= ALUControl;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      if (Zin & ~w_ready) r_ovf <= 1'b1;

      if (w_pop & w_wide) begin
        r_hi <= w_head_data[63:32];
        r_lo <= w_head_data[31:0];
      end
    end
  end

endmodule

// File: tb/tb_z_result_buffer.sv
module tb_z_result_buffer;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [4:0] T_MUL = 5'b01111;
  localparam logic [4:0] T_DIV = 5'b10000;
  localparam logic [4:0] T_ADD = 5'b00011;
  localparam logic [4:0] T_SUB = 5'b00100;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          Zin = 1'b0;
  logic [4:0]    ALUControl = '0;
  logic [63:0]   ZMuxIn = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   ZHighOut, ZLowOut, HIOut, LOOut;
  logic          flag_zero, flag_neg;
  logic [CW-1:0] count;
  logic          ovf_err;

  int checks = 0;
  int errors = 0;

  z_result_buffer #(.DEPTH(DEPTH), .WIDTH(64)) dut (
    .clock(clock), .clear(clear), .Zin(Zin), .ALUControl(ALUControl),
    .ZMuxIn(ZMuxIn), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .ZHighOut(ZHighOut), .ZLowOut(ZLowOut),
    .HIOut(HIOut), .LOOut(LOOut), .flag_zero(flag_zero), .flag_neg(flag_neg),
    .count(count), .ovf_err(ovf_err)
  );

  always #5 clock = ~clock;

  // ---------------- reference model: a queue of {tag, data} ----------------
  logic [68:0] mq[$];
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_ovf = 1'b0;

  function automatic bit is_wide(input logic [4:0] t);
    return (t == T_MUL) || (t == T_DIV);
  endfunction

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      mq.delete();
      m_hi = '0; m_lo = '0; m_ovf = 1'b0;
    end else begin
      bit rdy, pu, po;
      logic [68:0] h;
      rdy = (mq.size() < DEPTH) || out_ready;
      pu  = Zin && rdy;
      po  = (mq.size() > 0) && out_ready;
      if (Zin && !rdy) m_ovf = 1'b1;
      if (po) begin
        h = mq.pop_front();
        if (is_wide(h[68:64])) begin
          m_hi = h[63:32];
          m_lo = h[31:0];
        end
      end
      if (pu) mq.push_back({ALUControl, ZMuxIn});
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (clear) begin
      logic [63:0] hd;
      logic [4:0]  ht;
      bit e_z, e_n;
      hd = '0; ht = '0; e_z = 0; e_n = 0;
      if (mq.size() > 0) begin
        hd = mq[0][63:0];
        ht = mq[0][68:64];
        if (is_wide(ht)) begin e_z = (hd == 0); e_n = hd[63]; end
        else begin e_z = (hd[31:0] == 0); e_n = hd[31]; end
      end
      check("count",     64'(count),     64'(mq.size()));
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("in_ready",  64'(in_ready),  64'((mq.size() < DEPTH) || out_ready));
      check("head",      {ZHighOut, ZLowOut}, hd);
      check("flag_zero", 64'(flag_zero), 64'(e_z));
      check("flag_neg",  64'(flag_neg),  64'(e_n));
      check("HI",        64'(HIOut),     64'(m_hi));
      check("LO",        64'(LOOut),     64'(m_lo));
      check("ovf_err",   64'(ovf_err),   64'(m_ovf));
    end
  end

  // Inputs change only away from both clock edges.
  task automatic cyc(input bit z, input logic [4:0] t, input logic [63:0] d, input bit rdy);
    Zin = z; ALUControl = t; ZMuxIn = d; out_ready = rdy;
    @(posedge clock); #1;
  endtask

  task automatic at_neg();
    @(negedge clock); #1;
  endtask

  initial begin
    #3;
    check("reset count", 64'(count), 64'd0);
    check("reset valid", 64'(out_valid), 64'd0);
    check("reset head",  {ZHighOut, ZLowOut}, 64'd0);
    #9 clear = 1'b1;

    // Latency: visible one edge after push, even when empty.
    cyc(1, T_ADD, 64'h5, 0);
    at_neg();
    check("lat valid", 64'(out_valid), 64'd1);
    check("lat low",   64'(ZLowOut), 64'd5);
    check("lat zero",  64'(flag_zero), 64'd0);
    cyc(0, T_ADD, 0, 1);
    at_neg();
    check("lat count after pop", 64'(count), 64'd0);

    // Full / overflow: third push dropped.
    cyc(1, T_ADD, 64'hA1, 0);
    cyc(1, T_ADD, 64'hA2, 0);
    cyc(1, T_ADD, 64'hA3, 0);
    at_neg();
    check("full count", 64'(count), 64'd2);
    check("full in_ready", 64'(in_ready), 64'd0);
    check("ovf set", 64'(ovf_err), 64'd1);
    cyc(0, T_ADD, 0, 1);
    at_neg();
    check("ovf head2", 64'(ZLowOut), 64'hA2);
    cyc(0, T_ADD, 0, 1);
    at_neg();
    check("ovf drained", 64'(count), 64'd0);

    // Full pass-through.
    cyc(1, T_ADD, 64'hB1, 0);
    cyc(1, T_ADD, 64'hB2, 0);
    cyc(1, T_ADD, 64'hB3, 1);
    at_neg();
    check("pass count", 64'(count), 64'd2);
    check("pass head",  64'(ZLowOut), 64'hB2);
    check("pass ovf",   64'(ovf_err), 64'd1);
    cyc(0, T_ADD, 0, 1);
    at_neg();
    check("pass order", 64'(ZLowOut), 64'hB3);
    cyc(0, T_ADD, 0, 1);

    // HI/LO commit on mul pop; sub pop leaves them alone.
    cyc(1, T_MUL, 64'hFFFF_FFFF_8000_0000, 0);
    at_neg();
    check("mul neg", 64'(flag_neg), 64'd1);
    cyc(1, T_SUB, 64'h7, 1);
    at_neg();
    check("mul HI", 64'(HIOut), 64'hFFFF_FFFF);
    check("mul LO", 64'(LOOut), 64'h8000_0000);
    cyc(0, T_SUB, 0, 1);
    at_neg();
    check("sub HI kept", 64'(HIOut), 64'hFFFF_FFFF);
    check("sub LO kept", 64'(LOOut), 64'h8000_0000);

    // Flags narrow vs wide for the same value, then div is also wide.
    cyc(1, T_SUB, 64'hDEAD_0000_0000_0000, 0);
    at_neg();
    check("narrow zero", 64'(flag_zero), 64'd1);
    check("narrow neg",  64'(flag_neg),  64'd0);
    cyc(1, T_MUL, 64'hDEAD_0000_0000_0000, 1);
    at_neg();
    check("wide zero", 64'(flag_zero), 64'd0);
    check("wide neg",  64'(flag_neg),  64'd1);
    cyc(1, T_DIV, 64'h0000_0001_0000_0000, 1);
    at_neg();
    check("div zero", 64'(flag_zero), 64'd0);
    cyc(0, T_ADD, 0, 1);
    at_neg();
    check("div HI", 64'(HIOut), 64'h1);
    check("div LO", 64'(LOOut), 64'h0);

    // Reset mid-stream with two entries held.
    cyc(1, T_ADD, 64'hC1, 0);
    cyc(1, T_MUL, 64'hC2, 0);
    Zin = 1'b0;
    at_neg();
    clear = 1'b0;
    #1;
    check("rst count", 64'(count), 64'd0);
    check("rst valid", 64'(out_valid), 64'd0);
    check("rst HI", 64'(HIOut), 64'd0);
    check("rst LO", 64'(LOOut), 64'd0);
    check("rst ovf", 64'(ovf_err), 64'd0);
    #1 clear = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0]  t;
      logic [63:0] d;
      int sel;
      sel = $urandom_range(0, 3);
      t = (sel == 0) ? T_MUL : (sel == 1) ? T_DIV : 5'($urandom);
      d = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) d[31:0] = '0;
      if ($urandom_range(0, 7) == 0) d = '0;
      cyc(($urandom_range(0, 2) != 0), t, d, ($urandom_range(0, 1) == 1));
      if (i % 700 == 699) begin
        #1 clear = 1'b0;
        #1 clear = 1'b1;
      end
    end

    cyc(0, T_ADD, 0, 0);
    at_neg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
